// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: grant FSM encoding and the
// starvation counter width.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  // Width of the starvation counter; holds STARVE_MAX values up to 15.
  localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of back-to-back data grants taken while an instruction
// request is waiting. The clear input has priority over the increment input.
module arb_starve_counter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam logic [STARVE_W-1:0] MAX_V = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins; increment stops at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + STARVE_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sat = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port RAM arbiter between the instruction fetch (read-only) and the
// data requester (read/write). Data has priority unless the instruction side
// has been starved for STARVE_MAX consecutive data grants. A bubble cycle in
// IDLE separates every pair of grants.
// Optional build macro: MEM_ARB_PERF_EN adds the perf_icnt, perf_dcnt and
// perf_stall performance counter outputs.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              gnt_d
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_icnt,
  output logic [31:0]       perf_dcnt,
  output logic [31:0]       perf_stall
`endif
);

  arb_state_t state_q, state_d;
  logic       d_req;
  logic       i_done;
  logic       d_done;
  logic       starve_sat;

  assign d_req = dREN | dWEN;

  // Grant state register.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state, RAM port mux and requester handshake for the current owner.
  always_comb begin
    state_d  = state_q;
    iwait    = iREN;
    dwait    = d_req;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    gnt_d    = 1'b0;
    i_done   = 1'b0;
    d_done   = 1'b0;
    case (state_q)
      IDLE: begin
        // ram_ready here belongs to no grant and is ignored.
        if (d_req && !(iREN && starve_sat)) state_d = GNT_D;
        else if (iREN)                      state_d = GNT_I;
      end
      GNT_D: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        gnt_d    = 1'b1;
        if (!d_req) begin
          state_d = IDLE;
        end else if (ram_ready) begin
          d_done  = 1'b1;
          dwait   = 1'b0;
          dload   = ramload;
          state_d = IDLE;
        end
      end
      GNT_I: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          state_d = IDLE;
        end else if (ram_ready) begin
          i_done  = 1'b1;
          iwait   = 1'b0;
          iload   = ramload;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (i_done | ~iREN),
    .inc  (d_done & iREN),
    .sat  (starve_sat)
  );

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_icnt_q, perf_icnt_d;
  logic [31:0] perf_dcnt_q, perf_dcnt_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Completion and dual-stall counters, wrapping modulo 2^32.
  always_comb begin
    perf_icnt_d  = perf_icnt_q + 32'(i_done);
    perf_dcnt_d  = perf_dcnt_q + 32'(d_done);
    perf_stall_d = perf_stall_q + 32'(iwait & dwait);
  end

  // Performance counter registers.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      perf_icnt_q  <= '0;
      perf_dcnt_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_icnt_q  <= perf_icnt_d;
      perf_dcnt_q  <= perf_dcnt_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_icnt  = perf_icnt_q;
  assign perf_dcnt  = perf_dcnt_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: instruction read, data priority,
// starvation, withdrawal, asynchronous reset mid-access and, when
// MEM_ARB_PERF_EN is defined, the performance counters.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          iREN = 1'b0;
  logic [AW-1:0] iaddr = '0;
  logic          iwait;
  logic [DW-1:0] iload;
  logic          dREN = 1'b0;
  logic          dWEN = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic [DW-1:0] dstore = '0;
  logic          dwait;
  logic [DW-1:0] dload;
  logic          ramREN;
  logic          ramWEN;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [DW-1:0] ramload = '0;
  logic          ram_ready = 1'b0;
  logic          gnt_d;
`ifdef MEM_ARB_PERF_EN
  logic [31:0]   perf_icnt;
  logic [31:0]   perf_dcnt;
  logic [31:0]   perf_stall;
`endif

  int vectors = 0;
  int miscompares = 0;

  mem_bus_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_MAX (4)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dwait     (dwait),
    .dload     (dload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ram_ready (ram_ready),
    .gnt_d     (gnt_d)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_icnt  (perf_icnt),
    .perf_dcnt  (perf_dcnt),
    .perf_stall (perf_stall)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask

  task automatic smp;
    @(negedge CLK);
  endtask

  task automatic idle_inputs;
    iREN      = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    ram_ready = 1'b0;
    ramload   = '0;
  endtask

  task automatic do_reset;
    nRST = 1'b0;
    idle_inputs();
    nxt();
    nxt();
    nRST = 1'b1;
  endtask

  // Counts data completions until an instruction completion is seen.
  task automatic count_until_instr(output int ndata, output int done, output logic [DW-1:0] last_dload);
    ndata = 0;
    done = 0;
    last_dload = '0;
    for (int k = 0; k < 40 && done == 0; k++) begin
      @(negedge CLK);
      if (gnt_d && !dwait) begin
        ndata++;
        last_dload = dload;
      end
      if (ramREN && !gnt_d && !iwait) done = 1;
    end
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic read_i(input logic [AW-1:0] a);
    iREN = 1'b1;
    iaddr = a;
    ram_ready = 1'b1;
    ramload = 32'h0000_0011;
    nxt();
    nxt();
    iREN = 1'b0;
    ram_ready = 1'b0;
  endtask
`endif

  initial begin
    int n;
    int ok;
    logic [DW-1:0] ld;

    // Reset state.
    idle_inputs();
    nxt();
    smp();
    chk("rst_ramREN", 64'(ramREN), 64'd0);
    chk("rst_ramWEN", 64'(ramWEN), 64'd0);
    chk("rst_gnt_d", 64'(gnt_d), 64'd0);
    chk("rst_iwait", 64'(iwait), 64'd0);
    chk("rst_dwait", 64'(dwait), 64'd0);
    nxt();
    nRST = 1'b1;

    // Single instruction read, ready on the first grant cycle.
    iREN = 1'b1;
    iaddr = 32'h0000_0040;
    smp();
    chk("i_idle_iwait", 64'(iwait), 64'd1);
    chk("i_idle_ramREN", 64'(ramREN), 64'd0);
    nxt();
    ram_ready = 1'b1;
    ramload = 32'h2008_0005;
    smp();
    chk("i_ramREN", 64'(ramREN), 64'd1);
    chk("i_ramWEN", 64'(ramWEN), 64'd0);
    chk("i_ramaddr", 64'(ramaddr), 64'h40);
    chk("i_iwait", 64'(iwait), 64'd0);
    chk("i_iload", 64'(iload), 64'h2008_0005);
    chk("i_gnt_d", 64'(gnt_d), 64'd0);
    nxt();
    idle_inputs();
    smp();
    chk("i_after_ramREN", 64'(ramREN), 64'd0);
    chk("i_after_iload", 64'(iload), 64'd0);

    // Data priority: write wins over simultaneous instruction request.
    iREN = 1'b1;
    iaddr = 32'h0000_0080;
    dWEN = 1'b1;
    daddr = 32'h0000_0100;
    dstore = 32'hDEAD_BEEF;
    smp();
    chk("p_idle_iwait", 64'(iwait), 64'd1);
    chk("p_idle_dwait", 64'(dwait), 64'd1);
    nxt();
    for (int c = 0; c < 2; c++) begin
      smp();
      chk("p_ramWEN", 64'(ramWEN), 64'd1);
      chk("p_ramREN", 64'(ramREN), 64'd0);
      chk("p_ramaddr", 64'(ramaddr), 64'h100);
      chk("p_ramstore", 64'(ramstore), 64'hDEAD_BEEF);
      chk("p_dwait", 64'(dwait), 64'd1);
      chk("p_iwait", 64'(iwait), 64'd1);
      nxt();
    end
    ram_ready = 1'b1;
    smp();
    chk("p_done_dwait", 64'(dwait), 64'd0);
    chk("p_done_iwait", 64'(iwait), 64'd1);
    chk("p_done_gnt_d", 64'(gnt_d), 64'd1);
    nxt();
    dWEN = 1'b0;
    ram_ready = 1'b0;
    smp();
    chk("p_bubble_ramREN", 64'(ramREN), 64'd0);
    chk("p_bubble_ramWEN", 64'(ramWEN), 64'd0);
    chk("p_bubble_iwait", 64'(iwait), 64'd1);
    nxt();
    ram_ready = 1'b1;
    ramload = 32'h0000_0ABC;
    smp();
    chk("p_igrant_ramREN", 64'(ramREN), 64'd1);
    chk("p_igrant_ramaddr", 64'(ramaddr), 64'h80);
    chk("p_igrant_gnt_d", 64'(gnt_d), 64'd0);
    chk("p_igrant_iload", 64'(iload), 64'hABC);
    nxt();
    idle_inputs();

    // Starvation: continuous data reads against a held instruction request.
    iREN = 1'b1;
    iaddr = 32'h0000_0044;
    dREN = 1'b1;
    daddr = 32'h0000_0180;
    ram_ready = 1'b1;
    ramload = 32'h1234_5678;
    count_until_instr(n, ok, ld);
    chk("starve_igrant", 64'(ok), 64'd1);
    chk("starve_ndata", 64'(n), 64'd4);
    chk("starve_dload", 64'(ld), 64'h1234_5678);
    count_until_instr(n, ok, ld);
    chk("starve_clr_igrant", 64'(ok), 64'd1);
    chk("starve_clr_ndata", 64'(n), 64'd4);
    nxt();
    idle_inputs();

    // Withdrawal: data request dropped while granted.
    dREN = 1'b1;
    daddr = 32'h0000_0200;
    nxt();
    smp();
    chk("w_ramREN", 64'(ramREN), 64'd1);
    chk("w_ramaddr", 64'(ramaddr), 64'h200);
    chk("w_dwait", 64'(dwait), 64'd1);
    nxt();
    dREN = 1'b0;
    ram_ready = 1'b1;
    ramload = 32'h0000_0055;
    smp();
    chk("w_drop_dload", 64'(dload), 64'd0);
    nxt();
    smp();
    chk("w_idle_gnt_d", 64'(gnt_d), 64'd0);
    chk("w_idle_ramREN", 64'(ramREN), 64'd0);
    chk("w_idle_dload", 64'(dload), 64'd0);
    nxt();
    idle_inputs();

    // Reset mid-access with the starve counter part-way up.
    iREN = 1'b1;
    iaddr = 32'h0000_0048;
    dWEN = 1'b1;
    daddr = 32'h0000_0300;
    dstore = 32'hCAFE_F00D;
    ram_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20 && n < 3; k++) begin
      @(negedge CLK);
      if (gnt_d && !dwait) n++;
    end
    chk("r_pre_ndata", 64'(n), 64'd3);
    nxt();
    ram_ready = 1'b0;
    nxt();
    smp();
    chk("r_pre_ramWEN", 64'(ramWEN), 64'd1);
    chk("r_pre_ramaddr", 64'(ramaddr), 64'h300);
    #2;
    nRST = 1'b0;
    #1;
    chk("r_async_ramWEN", 64'(ramWEN), 64'd0);
    chk("r_async_ramREN", 64'(ramREN), 64'd0);
    chk("r_async_gnt_d", 64'(gnt_d), 64'd0);
    chk("r_async_dwait", 64'(dwait), 64'd1);
    nxt();
    nRST = 1'b1;
    ram_ready = 1'b1;
    count_until_instr(n, ok, ld);
    chk("r_post_igrant", 64'(ok), 64'd1);
    chk("r_post_ndata", 64'(n), 64'd4);
    nxt();
    idle_inputs();

`ifdef MEM_ARB_PERF_EN
    // Performance counters: 3 instruction reads, 2 data writes, 2 dual-wait cycles.
    do_reset();
    smp();
    chk("perf_rst_icnt", 64'(perf_icnt), 64'd0);
    chk("perf_rst_dcnt", 64'(perf_dcnt), 64'd0);
    chk("perf_rst_stall", 64'(perf_stall), 64'd0);
    nxt();
    read_i(32'h0000_0010);
    read_i(32'h0000_0014);
    iREN = 1'b1;
    iaddr = 32'h0000_0018;
    dWEN = 1'b1;
    daddr = 32'h0000_0400;
    ram_ready = 1'b1;
    nxt();
    nxt();
    nxt();
    nxt();
    dWEN = 1'b0;
    nxt();
    nxt();
    idle_inputs();
    smp();
    chk("perf_icnt", 64'(perf_icnt), 64'd3);
    chk("perf_dcnt", 64'(perf_dcnt), 64'd2);
    chk("perf_stall", 64'(perf_stall), 64'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
